// File: rtl/arbitro_registro.sv
// arbitro_registro: round-robin arbiter granting N_REQ requesters access to
// one shared register. Each access is IDLE -> ACCESS -> ACK, one cycle per
// phase. Every output is driven directly from a flop.
module arbitro_registro #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ-1:0]       rw,
    input  logic [N_REQ*WIDTH-1:0] wdata,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       ack,
    output logic [WIDTH-1:0]       rdata,
    output logic                   busy,
    output logic                   reg_read_write,
    output logic [WIDTH-1:0]       reg_data,
    input  logic [WIDTH-1:0]       reg_data_out
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [IW-1:0]      win_q, win_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic [WIDTH-1:0]   rdata_q, rdata_d;
    logic               busy_q, busy_d;
    logic               rrw_q, rrw_d;
    logic [WIDTH-1:0]   rdat_q, rdat_d;

    logic [IW-1:0]      sel;
    logic [IW-1:0]      cand;
    logic               found;
    logic [N_REQ-1:0]   sel_oh;
    logic [WIDTH-1:0]   sel_wd;

    // Round-robin search: first requester at or after ptr+1 (wrapping) wins.
    always_comb begin
        sel   = '0;
        cand  = '0;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IW'((int'(ptr_q) + k) % N_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    // Decode the winner into a one-hot grant and pick out its write data.
    always_comb begin
        sel_oh = '0;
        sel_wd = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (sel == IW'(i)) begin
                sel_oh[i] = 1'b1;
                sel_wd    = wdata[i*WIDTH +: WIDTH];
            end
        end
    end

    // State and registered outputs; reset clears everything at once, which
    // also drops reg_read_write so an in-flight write cannot commit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ptr_q   <= IW'(N_REQ - 1);
            win_q   <= '0;
            gnt_q   <= '0;
            ack_q   <= '0;
            rdata_q <= '0;
            busy_q  <= 1'b0;
            rrw_q   <= 1'b0;
            rdat_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            busy_q  <= busy_d;
            rrw_q   <= rrw_d;
            rdat_q  <= rdat_d;
        end
    end

    // Next state plus next values of the registered outputs for that state.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        gnt_d   = gnt_q;
        ack_d   = '0;
        rdata_d = rdata_q;
        busy_d  = busy_q;
        rrw_d   = 1'b0;
        rdat_d  = rdat_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = ACCESS;
                    win_d   = sel;
                    gnt_d   = sel_oh;
                    rrw_d   = rw[sel];
                    rdat_d  = sel_wd;
                    busy_d  = 1'b1;
                end else begin
                    gnt_d  = '0;
                    busy_d = 1'b0;
                end
            end
            ACCESS: begin
                // rrw_q still holds the latched operation during ACCESS.
                state_d = ACK;
                ack_d   = gnt_q;
                ptr_d   = win_q;
                if (!rrw_q) rdata_d = reg_data_out;
            end
            ACK: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign gnt            = gnt_q;
    assign ack            = ack_q;
    assign rdata          = rdata_q;
    assign busy           = busy_q;
    assign reg_read_write = rrw_q;
    assign reg_data       = rdat_q;

endmodule
